exhaustive_pattern_gen: RTL

//  Parametrised on-chip exhaustive stimulus sequencer for small combinational units (ALU slices, decoders).

---
 rtl/exhaustive_pattern_gen.sv | 110 +++++++++++
 1 files changed

// File: rtl/exhaustive_pattern_gen.sv
// exhaustive_pattern_gen: steps an IN_W-bit pattern through all 2^IN_W codes,
// holding each code for DWELL cycles and strobing sample_stb on the last dwell
// cycle of every code. busy/done track the run.
// Optional signature compaction of obs is enabled by defining PAT_GEN_MISR_EN.
module exhaustive_pattern_gen #(
    parameter int unsigned       IN_W     = 3,
    parameter int unsigned       OUT_W    = 2,
    parameter int unsigned       DWELL    = 100,
    parameter int unsigned       SIG_W    = 8,
    parameter logic [SIG_W-1:0]  SIG_POLY = 8'h1D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    output logic [IN_W-1:0]  pat,
    input  logic [OUT_W-1:0] obs,
    output logic             sample_stb,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] sig
);

    localparam int unsigned     CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  pat_q,   pat_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             stb_q,   stb_d;
    logic [SIG_W-1:0] sig_q,   sig_d;
    logic [SIG_W-1:0] misr_next;

`ifdef PAT_GEN_MISR_EN
    // Signature step: shift left with polynomial feedback, fold in obs.
    assign misr_next = {sig_q[SIG_W-2:0], 1'b0}
                     ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
                     ^ SIG_W'(obs);
`else
    logic unused_misr;
    assign unused_misr = ^{obs, SIG_POLY};
    assign misr_next   = '0;
`endif

    // Next-state: start handling, dwell counting, pattern advance and end of run.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    pat_d   = '0;
                    cnt_d   = '0;
                    sig_d   = '0;
                end
            end
            S_RUN: begin
                if (!hold) begin
                    if (cnt_q == LAST) begin
                        sig_d = misr_next;
                        cnt_d = '0;
                        pat_d = pat_q + 1'b1;
                        if (pat_q == '1) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Strobe is precomputed one cycle ahead so it comes straight from a flop.
        stb_d = (state_d == S_RUN) && (cnt_d == LAST);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            sig_q   <= sig_d;
        end
    end

    // The registered strobe is masked while hold pauses the sequencer.
    assign sample_stb = stb_q & ~hold;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign pat        = pat_q;
    assign sig        = sig_q;

endmodule
